hazard_controller: RTL and testbench
====================================

# hazard_controller

Central hazard and flow controller for the 5-stage pipelined MIPS core. It drives the enables and flushes of the PC and of the IF/ID, ID/EX and EX/MEM pipeline registers, and selects the next-PC source. It detects:
- load-use hazards,
- `jr` register hazards,
- jumps resolved in ID,
- taken branches resolved in MEM.

It also keeps stall and flush performance counters. It sits beside the Control unit and forwarding unit at the top level; all other datapath timing is unchanged.

## Interface
- `CNT_W`, 16 — width of the performance counters.
- `clk`  in  1  — system clock; rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `id_rs`  in  5  — ID-stage `instr[25:21]`.
- `id_rt`  in  5  — ID-stage `instr[20:16]`.
- `id_uses_rt`  in  1  — ID instruction reads rt (R-type, `beq`, `bne`, `sw`).
- `id_jump`  in  1  — ID instruction is `j` or `jal`.
- `id_jr`  in  1  — ID instruction is `jr`.
- `ex_mem_read`  in  1  — EX-stage instruction is a load.
- `ex_reg_write`  in  1  — EX-stage instruction writes a register.
- `ex_write_reg`  in  5  — EX-stage destination register.
- `mem_mem_read`  in  1  — MEM-stage instruction is a load.
- `mem_write_reg`  in  5  — MEM-stage destination register.
- `mem_branch_taken`  in  1  — branch condition true in MEM.
- `halt_req`  in  1  — debug freeze request.
- `pc_enable`  out  1  — PC register load enable.
- `if_id_enable`  out  1  — IF/ID register load enable.
- `if_id_flush`  out  1  — IF/ID register loads all-zero (nop).
- `id_ex_flush`  out  1  — ID/EX register loads all-zero.
- `ex_mem_flush`  out  1  — EX/MEM register loads all-zero.
- `pc_src`  out  2  — next-PC source: 00 = PC+4, 01 = jump target, 10 = `jr` register, 11 = branch target.
- `stall_count`  out  CNT_W  — number of stall cycles.
- `flush_count`  out  CNT_W  — number of flush events.

## Operation
**FSM states:** RUN, STALL, FLUSH, HALT. Reset state is RUN.

**Hazard terms (combinational):**
- `lu` = `ex_mem_read & (ex_write_reg != 0) & (ex_write_reg == id_rs | (id_uses_rt & ex_write_reg == id_rt))`
- `jrh` = `id_jr & id_rs != 0 & ((ex_reg_write & ex_write_reg == id_rs) | (mem_mem_read & mem_write_reg == id_rs))`

**Priority, evaluated every cycle (first match wins):**
1. `mem_branch_taken`: `if_id_flush`, `id_ex_flush` and `ex_mem_flush` = 1; `pc_src` = 11. Next state FLUSH. `flush_count` +1.
2. `halt_req`: `pc_enable` = `if_id_enable` = 0; `id_ex_flush` = 1. Next state HALT.
3. `lu` or `jrh`: `pc_enable` = `if_id_enable` = 0; `id_ex_flush` = 1. Next state STALL. `stall_count` +1.
4. `id_jr`: `pc_src` = 10; `if_id_flush` = 1. `flush_count` +1.
5. `id_jump`: `pc_src` = 01; `if_id_flush` = 1. `flush_count` +1.
6. Otherwise: all enables 1, all flushes 0, `pc_src` = 00.

**State-specific rules:**
- **FLUSH:** lasts exactly 1 cycle. Hazard terms 3–5 are masked, because ID holds a flushed bubble. Returns to RUN unless `mem_branch_taken` is asserted again.
- **STALL:** exits to RUN on the first cycle where neither `lu` nor `jrh` is true.
- **STALL duration:** at most 2 consecutive cycles. A `jr` following a load can stall twice (load in EX, then load in MEM). A third consecutive stall cycle is forced to RUN behaviour; this is a design guard.
- **HALT:** holds while `halt_req` = 1. A taken branch still wins over HALT, so an in-flight branch completes.

**Counters:** wrap modulo 2^CNT_W.

## Timing
- Control outputs are combinational from the inputs and the current state, and take effect at the next rising edge; zero-cycle latency.
- Only the state register, the consecutive-stall counter and the performance counters are sequential.
- **Reset values:** state = RUN; counters = 0. While `reset` = 0, the outputs are: `pc_enable` = 1, `if_id_enable` = 1, all flushes 0, `pc_src` = 00.
- Reset asserted mid-stall or mid-halt: returns to RUN asynchronously; counters clear.
- A branch and a load-use hazard in the same cycle produce a flush only; `stall_count` is unchanged.

## Structure
- Shared package `mips_pkg` holds:
  - the state enum: RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALT = 2'd3;
  - the `pc_src` constants: `PC_PLUS4`, `PC_JUMP`, `PC_JR`, `PC_BRANCH`;
  - the register-zero constant.
- One sub-module, `hazard_compare`, contains the purely combinational `lu`/`jrh` comparators. The FSM and the counters stay in `hazard_controller`.

## Test plan
- **Load-use stall:** `lw $t0` in EX (`ex_write_reg` = 8, `ex_mem_read` = 1); `add` in ID with `id_rs` = 8.
  - Required: exactly one cycle with `pc_enable` = 0 and `id_ex_flush` = 1; `stall_count` = 1; next cycle in RUN.
- **`jr` after load:** `id_jr` = 1, `id_rs` = 31. Load to $31 in EX, then in MEM.
  - Required: two stall cycles; then `pc_src` = 10 and `if_id_flush` = 1; `stall_count` = 2.
- **Branch beats stall:** `mem_branch_taken` = 1 together with an `lu` condition.
  - Required: `if_id_flush`, `id_ex_flush` and `ex_mem_flush` = 1; `pc_src` = 11; `stall_count` unchanged; next state FLUSH.
  - Also required: `id_jump` = 1 during the FLUSH cycle is ignored.
- **Register zero:** load to $0 in EX with `id_rs` = 0.
  - Required: no stall.
- **Halt:** `halt_req` high for 5 cycles.
  - Required: `pc_enable` = 0 for 5 cycles, then normal operation.
  - Also required: async `reset` pulse mid-halt returns the block to RUN with counters = 0.
- **Counter wrap:** with `CNT_W` = 4, apply 17 load-use stalls.
  - Required: `stall_count` = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Definitions shared by the MIPS pipeline control blocks: hazard FSM states,
// next-PC source codes and the hard-wired zero register.
package mips_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } hz_state_t;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_BRANCH = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Longest legitimate run of back-to-back stalls (jr waiting on a load).
  localparam logic [1:0] MAX_STALL = 2'd2;

endpackage

// File: rtl/hazard_compare.sv
// Register-match comparators that flag load-use and jr operand hazards.
// Purely combinational; the controller decides what to do with them.
module hazard_compare
  import mips_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jr,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_write_reg,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_write_reg,
  output logic       lu,
  output logic       jrh
);

  logic ex_hits_rs;
  logic ex_hits_rt;
  logic mem_hits_rs;

  assign ex_hits_rs  = (ex_write_reg == id_rs);
  assign ex_hits_rt  = id_uses_rt && (ex_write_reg == id_rt);
  assign mem_hits_rs = (mem_write_reg == id_rs);

  assign lu = ex_mem_read && (ex_write_reg != REG_ZERO) && (ex_hits_rs || ex_hits_rt);

  // jr reads its target in ID, so it cannot use forwarding from EX at all,
  // and a load still in MEM has no data to forward yet.
  assign jrh = id_jr && (id_rs != REG_ZERO) &&
               ((ex_reg_write && ex_hits_rs) || (mem_mem_read && mem_hits_rs));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard/flow controller: drives PC and pipeline-register enables and
// flushes, selects next-PC source, and counts stall cycles and flush events.
module hazard_controller
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             id_jr,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic [4:0]       ex_write_reg,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_write_reg,
  input  logic             mem_branch_taken,
  input  logic             halt_req,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic [1:0]       pc_src,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t  state;
  hz_state_t  state_nxt;
  logic [1:0] stall_run;
  logic       lu;
  logic       jrh;
  logic       id_live;
  logic       stall_ok;
  logic       stall_evt;
  logic       flush_evt;

  hazard_compare u_cmp (
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_jr         (id_jr),
    .ex_mem_read   (ex_mem_read),
    .ex_reg_write  (ex_reg_write),
    .ex_write_reg  (ex_write_reg),
    .mem_mem_read  (mem_mem_read),
    .mem_write_reg (mem_write_reg),
    .lu            (lu),
    .jrh           (jrh)
  );

  // After a flush, ID holds a bubble whose decode fields are meaningless.
  assign id_live  = (state != FLUSH);
  assign stall_ok = (stall_run < MAX_STALL);

  always_comb begin
    pc_enable    = 1'b1;
    if_id_enable = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    pc_src       = PC_PLUS4;
    state_nxt    = RUN;
    stall_evt    = 1'b0;
    flush_evt    = 1'b0;
    if (reset) begin
      if (mem_branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        pc_src       = PC_BRANCH;
        state_nxt    = FLUSH;
        flush_evt    = 1'b1;
      end else if (halt_req) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
        state_nxt    = HALT;
      end else if (id_live && stall_ok && (lu || jrh)) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
        state_nxt    = STALL;
        stall_evt    = 1'b1;
      end else if (id_live && id_jr) begin
        pc_src      = PC_JR;
        if_id_flush = 1'b1;
        flush_evt   = 1'b1;
      end else if (id_live && id_jump) begin
        pc_src      = PC_JUMP;
        if_id_flush = 1'b1;
        flush_evt   = 1'b1;
      end
    end
  end

  // State, consecutive-stall run length and performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      stall_run   <= 2'd0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state     <= state_nxt;
      stall_run <= stall_evt ? stall_run + 2'd1 : 2'd0;
      if (stall_evt) stall_count <= stall_count + 1'b1;
      if (flush_evt) flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Scenario bench for hazard_controller; a 16-bit and a 4-bit counter instance
// share all inputs so the wrap case runs alongside the normal checks.
module tb_hazard_controller;
  import mips_pkg::*;

  typedef struct packed {
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       id_jump;
    logic       id_jr;
    logic       ex_mem_read;
    logic       ex_reg_write;
    logic [4:0] ex_write_reg;
    logic       mem_mem_read;
    logic [4:0] mem_write_reg;
    logic       mem_branch_taken;
    logic       halt_req;
  } stim_t;

  // {pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, pc_src}
  localparam logic [6:0] C_NORM   = 7'b11_000_00;
  localparam logic [6:0] C_STALL  = 7'b00_010_00;
  localparam logic [6:0] C_HALT   = 7'b00_010_00;
  localparam logic [6:0] C_BRANCH = 7'b11_111_11;
  localparam logic [6:0] C_JR     = 7'b11_100_10;
  localparam logic [6:0] C_JUMP   = 7'b11_100_01;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs, id_rt, ex_write_reg, mem_write_reg;
  logic        id_uses_rt, id_jump, id_jr, ex_mem_read, ex_reg_write;
  logic        mem_mem_read, mem_branch_taken, halt_req;
  logic        pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]  pc_src;
  logic [15:0] stall_count, flush_count;
  logic        w_pc_enable, w_if_id_enable, w_if_id_flush, w_id_ex_flush, w_ex_mem_flush;
  logic [1:0]  w_pc_src;
  logic [3:0]  w_stall_count, w_flush_count;
  logic [6:0]  ctl, ctl_w;

  logic [6:0]  exp_q[$];
  int          total = 0;
  int          passed = 0;
  int          exp_stall = 0;
  int          exp_flush = 0;

  always #5 clk = ~clk;

  assign ctl   = {pc_enable, if_id_enable, if_id_flush, id_ex_flush, ex_mem_flush, pc_src};
  assign ctl_w = {w_pc_enable, w_if_id_enable, w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_pc_src};

  hazard_controller #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_jr(id_jr), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg), .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
    .mem_branch_taken(mem_branch_taken), .halt_req(halt_req), .pc_enable(pc_enable),
    .if_id_enable(if_id_enable), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .pc_src(pc_src), .stall_count(stall_count),
    .flush_count(flush_count)
  );

  hazard_controller #(.CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .id_jr(id_jr), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .ex_write_reg(ex_write_reg), .mem_mem_read(mem_mem_read), .mem_write_reg(mem_write_reg),
    .mem_branch_taken(mem_branch_taken), .halt_req(halt_req), .pc_enable(w_pc_enable),
    .if_id_enable(w_if_id_enable), .if_id_flush(w_if_id_flush), .id_ex_flush(w_id_ex_flush),
    .ex_mem_flush(w_ex_mem_flush), .pc_src(w_pc_src), .stall_count(w_stall_count),
    .flush_count(w_flush_count)
  );

  task automatic apply(input stim_t s);
    id_rs            = s.id_rs;
    id_rt            = s.id_rt;
    id_uses_rt       = s.id_uses_rt;
    id_jump          = s.id_jump;
    id_jr            = s.id_jr;
    ex_mem_read      = s.ex_mem_read;
    ex_reg_write     = s.ex_reg_write;
    ex_write_reg     = s.ex_write_reg;
    mem_mem_read     = s.mem_mem_read;
    mem_write_reg    = s.mem_write_reg;
    mem_branch_taken = s.mem_branch_taken;
    halt_req         = s.halt_req;
  endtask

  function automatic stim_t lu_stim(input logic [4:0] r);
    stim_t s;
    s = '0;
    s.ex_mem_read  = 1'b1;
    s.ex_reg_write = 1'b1;
    s.ex_write_reg = r;
    s.id_rs        = r;
    return s;
  endfunction

  task automatic test_reset();
    stim_t s;
    s = lu_stim(5'd8);
    apply(s);
    #1 reset = 1'b0;
    #1;
    exp_q.push_back(C_NORM);
    begin
      logic [6:0] e;
      e = exp_q.pop_front();
      total++;
      if (ctl === e && ctl_w === e) passed++;
      else $display("FAIL reset_ctl: ctl=%b ctl_w=%b required %b", ctl, ctl_w, e);
    end
    total++;
    if (stall_count === 16'd0 && flush_count === 16'd0 && w_stall_count === 4'd0 && w_flush_count === 4'd0)
      passed++;
    else
      $display("FAIL reset_counters: stall=%0d flush=%0d w_stall=%0d w_flush=%0d required 0",
               stall_count, flush_count, w_stall_count, w_flush_count);
    @(negedge clk);
    apply('0);
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_load_use();
    stim_t      s[4];
    logic [6:0] e[4];
    logic [6:0] got;
    s[0] = lu_stim(5'd8);                                            e[0] = C_STALL;
    s[1] = '0; s[1].mem_mem_read = 1'b1; s[1].mem_write_reg = 5'd8;
    s[1].id_rs = 5'd8;                                               e[1] = C_NORM;
    s[2] = lu_stim(5'd9); s[2].id_rs = 5'd3; s[2].id_rt = 5'd9;
    s[2].id_uses_rt = 1'b1;                                          e[2] = C_STALL;
    s[3] = s[2]; s[3].id_uses_rt = 1'b0;                             e[3] = C_NORM;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = exp_q.pop_front();
      total++;
      if (ctl === got && ctl_w === got) passed++;
      else $display("FAIL load_use_c%0d: ctl=%b ctl_w=%b required %b", i, ctl, ctl_w, got);
    end
    exp_stall += 2;
    @(negedge clk);
    apply('0);
    #1;
    total++;
    if (stall_count === 16'(exp_stall) && flush_count === 16'(exp_flush)) passed++;
    else $display("FAIL load_use_counts: stall=%0d flush=%0d required %0d/%0d",
                  stall_count, flush_count, exp_stall, exp_flush);
  endtask

  task automatic test_jr_after_load();
    stim_t      s[3];
    logic [6:0] e[3];
    logic [6:0] got;
    s[0] = lu_stim(5'd31); s[0].id_jr = 1'b1;                        e[0] = C_STALL;
    s[1] = '0; s[1].id_jr = 1'b1; s[1].id_rs = 5'd31;
    s[1].mem_mem_read = 1'b1; s[1].mem_write_reg = 5'd31;            e[1] = C_STALL;
    s[2] = '0; s[2].id_jr = 1'b1; s[2].id_rs = 5'd31;                e[2] = C_JR;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = exp_q.pop_front();
      total++;
      if (ctl === got) passed++;
      else $display("FAIL jr_load_c%0d: ctl=%b required %b", i, ctl, got);
    end
    exp_stall += 2;
    exp_flush += 1;
    @(negedge clk);
    apply('0);
    #1;
    total++;
    if (stall_count === 16'(exp_stall) && flush_count === 16'(exp_flush)) passed++;
    else $display("FAIL jr_load_counts: stall=%0d flush=%0d required %0d/%0d",
                  stall_count, flush_count, exp_stall, exp_flush);
  endtask

  task automatic test_branch();
    stim_t      s[6];
    logic [6:0] e[6];
    logic [6:0] got;
    s[0] = lu_stim(5'd8); s[0].mem_branch_taken = 1'b1;              e[0] = C_BRANCH;
    s[1] = lu_stim(5'd8); s[1].id_jump = 1'b1;                       e[1] = C_NORM;
    s[2] = '0; s[2].id_jump = 1'b1;                                  e[2] = C_JUMP;
    s[3] = '0; s[3].mem_branch_taken = 1'b1;                         e[3] = C_BRANCH;
    s[4] = '0; s[4].mem_branch_taken = 1'b1; s[4].id_jr = 1'b1;      e[4] = C_BRANCH;
    s[5] = '0; s[5].id_jump = 1'b1;                                  e[5] = C_NORM;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = exp_q.pop_front();
      total++;
      if (ctl === got && ctl_w === got) passed++;
      else $display("FAIL branch_c%0d: ctl=%b ctl_w=%b required %b", i, ctl, ctl_w, got);
    end
    exp_flush += 4;
    @(negedge clk);
    apply('0);
    #1;
    total++;
    if (stall_count === 16'(exp_stall) && flush_count === 16'(exp_flush)) passed++;
    else $display("FAIL branch_counts: stall=%0d flush=%0d required %0d/%0d",
                  stall_count, flush_count, exp_stall, exp_flush);
  endtask

  task automatic test_reg_zero();
    stim_t      s[4];
    logic [6:0] e[4];
    logic [6:0] got;
    s[0] = lu_stim(5'd0); s[0].id_uses_rt = 1'b1;                    e[0] = C_NORM;
    s[1] = '0; s[1].id_jr = 1'b1; s[1].ex_reg_write = 1'b1;          e[1] = C_JR;
    s[2] = '0; s[2].id_jr = 1'b1; s[2].id_rs = 5'd5;
    s[2].mem_mem_read = 1'b1; s[2].mem_write_reg = 5'd5;             e[2] = C_STALL;
    s[3] = s[2]; s[3].mem_mem_read = 1'b0;                           e[3] = C_JR;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = exp_q.pop_front();
      total++;
      if (ctl === got) passed++;
      else $display("FAIL reg_zero_c%0d: ctl=%b required %b", i, ctl, got);
    end
    exp_stall += 1;
    exp_flush += 2;
  endtask

  task automatic test_stall_guard();
    stim_t      s[5];
    logic [6:0] e[5];
    logic [6:0] got;
    for (int i = 0; i < 4; i++) s[i] = lu_stim(5'd12);
    s[4] = '0;
    e[0] = C_STALL; e[1] = C_STALL; e[2] = C_NORM; e[3] = C_STALL; e[4] = C_NORM;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = exp_q.pop_front();
      total++;
      if (ctl === got) passed++;
      else $display("FAIL stall_guard_c%0d: ctl=%b required %b", i, ctl, got);
    end
    exp_stall += 3;
    @(negedge clk);
    apply('0);
    #1;
    total++;
    if (stall_count === 16'(exp_stall) && flush_count === 16'(exp_flush)) passed++;
    else $display("FAIL stall_guard_counts: stall=%0d flush=%0d required %0d/%0d",
                  stall_count, flush_count, exp_stall, exp_flush);
  endtask

  task automatic test_halt();
    stim_t      s[9];
    logic [6:0] e[9];
    logic [6:0] got;
    for (int i = 0; i < 5; i++) begin
      s[i] = '0; s[i].halt_req = 1'b1; e[i] = C_HALT;
    end
    s[5] = '0;                                                       e[5] = C_NORM;
    s[6] = '0; s[6].halt_req = 1'b1;                                 e[6] = C_HALT;
    s[7] = s[6]; s[7].mem_branch_taken = 1'b1;                       e[7] = C_BRANCH;
    s[8] = s[6];                                                     e[8] = C_HALT;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      apply(s[i]);
      exp_q.push_back(e[i]);
      #2;
      got = exp_q.pop_front();
      total++;
      if (ctl === got) passed++;
      else $display("FAIL halt_c%0d: ctl=%b required %b", i, ctl, got);
    end
    exp_flush += 1;
    // Asynchronous reset pulse while still halted.
    #1 reset = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    exp_q.push_back(C_NORM);
    got = exp_q.pop_front();
    total++;
    if (ctl === got && stall_count === 16'd0 && flush_count === 16'd0 && w_stall_count === 4'd0)
      passed++;
    else
      $display("FAIL halt_reset: ctl=%b stall=%0d flush=%0d required ctl %b counters 0",
               ctl, stall_count, flush_count, got);
    @(negedge clk);
    apply('0);
    reset = 1'b1;
    s[0] = '0; s[0].id_jump = 1'b1;
    @(negedge clk);
    apply(s[0]);
    exp_q.push_back(C_JUMP);
    #2;
    got = exp_q.pop_front();
    total++;
    if (ctl === got) passed++;
    else $display("FAIL halt_after_reset: ctl=%b required %b", ctl, got);
    exp_flush += 1;
  endtask

  task automatic test_counter_wrap();
    logic [6:0] got;
    @(negedge clk);
    apply('0);
    reset = 1'b0;
    #1;
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      apply(lu_stim(5'(i + 1)));
      exp_q.push_back(C_STALL);
      #2;
      got = exp_q.pop_front();
      total++;
      if (ctl_w === got) passed++;
      else $display("FAIL wrap_stall_%0d: ctl_w=%b required %b", i, ctl_w, got);
      exp_stall++;
      @(negedge clk);
      apply('0);
    end
    #1;
    total++;
    if (w_stall_count === 4'd1 && w_flush_count === 4'd0) passed++;
    else $display("FAIL wrap_count4: stall=%0d flush=%0d required 1/0", w_stall_count, w_flush_count);
    total++;
    if (stall_count === 16'(exp_stall)) passed++;
    else $display("FAIL wrap_count16: stall=%0d required %0d", stall_count, exp_stall);
  endtask

  initial begin
    apply('0);
    test_reset();
    test_load_use();
    test_jr_after_load();
    test_branch();
    test_reg_zero();
    test_stall_guard();
    test_halt();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
